hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage MIPS core. It detects load-use hazards with a configurable number of bubble cycles, honours only the source registers an instruction actually reads, and squashes IF/ID and ID/EX on a taken branch from EX. It also holds ID while the multi-cycle mul/div unit is busy, and counts stall cycles for performance monitoring. It sits beside the ID stage and drives the PC, IF/ID and ID/EX register mux selects.

---
 rtl/hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller beside ID: load-use bubbles, taken-branch squash, mul/div hold
// and a saturating stall-cycle counter. Mux selects respond combinationally.
module hazard_ctrl #(
    parameter int REG_W     = 5,
    parameter int LOAD_LAT  = 1,
    parameter int ZERO_SKIP = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_rs_used,
    input  logic             ifid_rt_used,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             ex_branch_taken,
    input  logic             id_mdu_req,
    input  logic             mdu_busy,
    output logic [1:0]       pc_mux,
    output logic [1:0]       ifid_mux,
    output logic [1:0]       idex_mux,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        MDU_WAIT  = 2'd2
    } state_t;

    localparam int              REM_W    = 3;
    localparam logic [REM_W-1:0] LOAD_REM = REM_W'(LOAD_LAT - 1);

    localparam logic [1:0] SEL_ADVANCE = 2'b00;
    localparam logic [1:0] SEL_HOLD    = 2'b10;
    localparam logic [1:0] SEL_SQUASH  = 2'b01;

    state_t           state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic rs_hit, rt_hit, zero_blocked, lu, mdu_stall, use_idle_rules;

    assign rs_hit       = ifid_rs_used && (ifid_rs == idex_rt);
    assign rt_hit       = ifid_rt_used && (ifid_rt == idex_rt);
    assign zero_blocked = (ZERO_SKIP != 0) && (idex_rt == '0);
    assign lu           = idex_memread && (rs_hit || rt_hit) && !zero_blocked;
    assign mdu_stall    = id_mdu_req && mdu_busy;

    // A fresh load-use seen while waiting on the MDU takes the IDLE path directly.
    assign use_idle_rules = (state_q == IDLE) || ((state_q == MDU_WAIT) && lu);

    always_comb begin
        // NOTE: every signal gets a default here so no path can infer a latch.
        pc_mux       = SEL_ADVANCE;
        ifid_mux     = SEL_ADVANCE;
        idex_mux     = SEL_ADVANCE;
        stall_active = 1'b0;
        state_d      = state_q;
        rem_d        = rem_q;

        if (rst) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (ex_branch_taken) begin
            ifid_mux = SEL_SQUASH;
            idex_mux = SEL_SQUASH;
            state_d  = IDLE;
            rem_d    = '0;
        end else if (use_idle_rules) begin
            if (lu) begin
                stall_active = 1'b1;
                if (LOAD_LAT > 1) begin
                    state_d = LOAD_WAIT;
                    rem_d   = LOAD_REM;
                end else begin
                    state_d = IDLE;
                end
            end else if (mdu_stall) begin
                stall_active = 1'b1;
                state_d      = MDU_WAIT;
            end
        end else if (state_q == LOAD_WAIT) begin
            stall_active = 1'b1;
            rem_d        = rem_q - REM_W'(1);
            if (rem_q == REM_W'(1)) begin
                state_d = mdu_stall ? MDU_WAIT : IDLE;
            end
        end else begin
            if (mdu_busy) begin
                stall_active = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end

        if (stall_active) begin
            pc_mux   = SEL_HOLD;
            ifid_mux = SEL_HOLD;
            idex_mux = SEL_SQUASH;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_active && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            rem_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: five parameter variants share one stimulus stream,
// expected selects are queued per cycle and compared at the falling edge.
module tb_hazard_ctrl;

    localparam int REG_W = 5;
    localparam logic [6:0] E_IDLE  = 7'b00_00_00_0;
    localparam logic [6:0] E_STALL = 7'b10_10_01_1;
    localparam logic [6:0] E_FLUSH = 7'b00_01_01_0;

    // Variant indices
    localparam int D_L1 = 0;
    localparam int D_L3 = 1;
    localparam int D_L2 = 2;
    localparam int D_Z0 = 3;
    localparam int D_C4 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [REG_W-1:0] ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
    logic ifid_rs_used = 1'b0, ifid_rt_used = 1'b0, idex_memread = 1'b0;
    logic ex_branch_taken = 1'b0, id_mdu_req = 1'b0, mdu_busy = 1'b0;

    logic [1:0]  pc_mux   [5];
    logic [1:0]  ifid_mux [5];
    logic [1:0]  idex_mux [5];
    logic        stall_active [5];
    logic [15:0] sc [4];
    logic [3:0]  sc_c4;
    logic [6:0]  obs [5];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         dut;
        logic [6:0] exp;
        string      tag;
    } sb_entry_t;

    sb_entry_t sb[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(REG_W), .LOAD_LAT(1), .ZERO_SKIP(1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_rs_used(ifid_rs_used), .ifid_rt_used(ifid_rt_used),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ex_branch_taken(ex_branch_taken), .id_mdu_req(id_mdu_req), .mdu_busy(mdu_busy),
        .pc_mux(pc_mux[D_L1]), .ifid_mux(ifid_mux[D_L1]), .idex_mux(idex_mux[D_L1]),
        .stall_active(stall_active[D_L1]), .stall_cycles(sc[D_L1]));

    hazard_ctrl #(.REG_W(REG_W), .LOAD_LAT(3), .ZERO_SKIP(1), .CNT_W(16)) u_l3 (
        .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_rs_used(ifid_rs_used), .ifid_rt_used(ifid_rt_used),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ex_branch_taken(ex_branch_taken), .id_mdu_req(id_mdu_req), .mdu_busy(mdu_busy),
        .pc_mux(pc_mux[D_L3]), .ifid_mux(ifid_mux[D_L3]), .idex_mux(idex_mux[D_L3]),
        .stall_active(stall_active[D_L3]), .stall_cycles(sc[D_L3]));

    hazard_ctrl #(.REG_W(REG_W), .LOAD_LAT(2), .ZERO_SKIP(1), .CNT_W(16)) u_l2 (
        .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_rs_used(ifid_rs_used), .ifid_rt_used(ifid_rt_used),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ex_branch_taken(ex_branch_taken), .id_mdu_req(id_mdu_req), .mdu_busy(mdu_busy),
        .pc_mux(pc_mux[D_L2]), .ifid_mux(ifid_mux[D_L2]), .idex_mux(idex_mux[D_L2]),
        .stall_active(stall_active[D_L2]), .stall_cycles(sc[D_L2]));

    hazard_ctrl #(.REG_W(REG_W), .LOAD_LAT(1), .ZERO_SKIP(0), .CNT_W(16)) u_z0 (
        .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_rs_used(ifid_rs_used), .ifid_rt_used(ifid_rt_used),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ex_branch_taken(ex_branch_taken), .id_mdu_req(id_mdu_req), .mdu_busy(mdu_busy),
        .pc_mux(pc_mux[D_Z0]), .ifid_mux(ifid_mux[D_Z0]), .idex_mux(idex_mux[D_Z0]),
        .stall_active(stall_active[D_Z0]), .stall_cycles(sc[D_Z0]));

    hazard_ctrl #(.REG_W(REG_W), .LOAD_LAT(1), .ZERO_SKIP(1), .CNT_W(4)) u_c4 (
        .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_rs_used(ifid_rs_used), .ifid_rt_used(ifid_rt_used),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ex_branch_taken(ex_branch_taken), .id_mdu_req(id_mdu_req), .mdu_busy(mdu_busy),
        .pc_mux(pc_mux[D_C4]), .ifid_mux(ifid_mux[D_C4]), .idex_mux(idex_mux[D_C4]),
        .stall_active(stall_active[D_C4]), .stall_cycles(sc_c4));

    for (genvar g = 0; g < 5; g++) begin : g_obs
        assign obs[g] = {pc_mux[g], ifid_mux[g], idex_mux[g], stall_active[g]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input int dut, input logic [6:0] exp, input string tag);
        sb_entry_t e;
        e.dut = dut;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Compare everything queued for this cycle at the falling edge, then advance one edge.
    task automatic step();
        sb_entry_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, 32'(obs[e.dut]), 32'(e.exp));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifid_rs = '0; ifid_rt = '0; idex_rt = '0;
        ifid_rs_used = 1'b0; ifid_rt_used = 1'b0; idex_memread = 1'b0;
        ex_branch_taken = 1'b0; id_mdu_req = 1'b0; mdu_busy = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load_use(input logic [REG_W-1:0] r);
        idex_memread = 1'b1; idex_rt = r; ifid_rs = r; ifid_rs_used = 1'b1;
    endtask

    initial begin
        // Reset holds outputs low even with a live hazard on the inputs.
        rst = 1'b1;
        drive_load_use(5'd8);
        id_mdu_req = 1'b1; mdu_busy = 1'b1;
        #7;
        check("rst_out_l1", 32'(obs[D_L1]), 32'(E_IDLE));
        check("rst_out_l3", 32'(obs[D_L3]), 32'(E_IDLE));
        check("rst_cnt", 32'(sc[D_L1]), 32'd0);
        do_reset();

        // Single-cycle load-use, LOAD_LAT=1
        drive_load_use(5'd8);
        expect_out(D_L1, E_STALL, "lu1_c1");
        step();
        clear_inputs();
        expect_out(D_L1, E_IDLE, "lu1_c2");
        step();
        expect_out(D_L1, E_IDLE, "lu1_c3");
        step();
        check("lu1_cnt", 32'(sc[D_L1]), 32'd1);

        // Load-use held one cycle, LOAD_LAT=3 and LOAD_LAT=2
        do_reset();
        drive_load_use(5'd8);
        expect_out(D_L3, E_STALL, "lu3_c1");
        expect_out(D_L2, E_STALL, "lu2_c1");
        step();
        clear_inputs();
        expect_out(D_L3, E_STALL, "lu3_c2");
        expect_out(D_L2, E_STALL, "lu2_c2");
        step();
        expect_out(D_L3, E_STALL, "lu3_c3");
        expect_out(D_L2, E_IDLE,  "lu2_c3");
        step();
        expect_out(D_L3, E_IDLE, "lu3_c4");
        step();
        check("lu3_cnt", 32'(sc[D_L3]), 32'd3);
        check("lu2_cnt", 32'(sc[D_L2]), 32'd2);

        // False-stall filters: unused rt, and register 0
        do_reset();
        idex_memread = 1'b1; idex_rt = 5'd9; ifid_rt = 5'd9; ifid_rt_used = 1'b0;
        ifid_rs = 5'd3; ifid_rs_used = 1'b1;
        expect_out(D_L1, E_IDLE, "rt_unused");
        step();
        ifid_rt_used = 1'b1;
        expect_out(D_L1, E_STALL, "rt_used");
        step();
        clear_inputs();
        drive_load_use(5'd0);
        expect_out(D_L1, E_IDLE,  "zero_skip1");
        expect_out(D_Z0, E_STALL, "zero_skip0");
        step();
        clear_inputs();
        expect_out(D_Z0, E_IDLE, "zero_skip0_after");
        step();
        check("zs0_cnt", 32'(sc[D_Z0]), 32'd2);

        // Flush in the second stall cycle of a LOAD_LAT=3 hazard
        do_reset();
        drive_load_use(5'd12);
        expect_out(D_L3, E_STALL, "fl_c1");
        step();
        clear_inputs();
        ex_branch_taken = 1'b1;
        expect_out(D_L3, E_FLUSH, "fl_c2");
        step();
        ex_branch_taken = 1'b0;
        expect_out(D_L3, E_IDLE, "fl_c3");
        step();
        check("fl_cnt", 32'(sc[D_L3]), 32'd1);

        // MDU hold for four busy cycles
        do_reset();
        id_mdu_req = 1'b1; mdu_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_out(D_L1, E_STALL, $sformatf("mdu_c%0d", i));
            step();
        end
        mdu_busy = 1'b0;
        expect_out(D_L1, E_IDLE, "mdu_drop");
        step();
        id_mdu_req = 1'b0;
        expect_out(D_L1, E_IDLE, "mdu_after");
        step();
        check("mdu_cnt", 32'(sc[D_L1]), 32'd4);

        // Load-use together with MDU busy, LOAD_LAT=2
        do_reset();
        drive_load_use(5'd7);
        id_mdu_req = 1'b1; mdu_busy = 1'b1;
        expect_out(D_L2, E_STALL, "lumdu_c1");
        step();
        idex_memread = 1'b0; ifid_rs_used = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            expect_out(D_L2, E_STALL, $sformatf("lumdu_c%0d", i));
            step();
        end
        mdu_busy = 1'b0;
        expect_out(D_L2, E_IDLE, "lumdu_drop");
        step();
        check("lumdu_cnt", 32'(sc[D_L2]), 32'd4);

        // Asynchronous reset in the middle of LOAD_WAIT
        do_reset();
        drive_load_use(5'd8);
        expect_out(D_L3, E_STALL, "arst_c1");
        step();
        clear_inputs();
        #2;
        rst = 1'b1;
        #1;
        check("arst_out", 32'(obs[D_L3]), 32'(E_IDLE));
        check("arst_cnt", 32'(sc[D_L3]), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        expect_out(D_L3, E_IDLE, "arst_post1");
        step();
        expect_out(D_L3, E_IDLE, "arst_post2");
        step();
        check("arst_cnt_post", 32'(sc[D_L3]), 32'd0);

        // Counter saturation with CNT_W=4 across 21 stall cycles
        do_reset();
        id_mdu_req = 1'b1; mdu_busy = 1'b1;
        for (int i = 0; i < 21; i++) begin
            expect_out(D_C4, E_STALL, $sformatf("sat_c%0d", i));
            step();
        end
        clear_inputs();
        expect_out(D_C4, E_IDLE, "sat_drop");
        step();
        check("sat_cnt4", 32'(sc_c4), 32'd15);
        check("sat_cnt16", 32'(sc[D_L1]), 32'd21);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
